sigmoid_sched: RTL and testbench

Round-robin scheduler that shares one pipelined `sigmoid` activation unit among `N_REQ` neuron requesters. Each requester offers a 17-bit pre-activation operand with a valid/ready handshake. The block issues at most one operand per cycle to the shared unit and tracks a requester tag through a latency-matched pipeline. It returns each result as a one-hot response to the requester that issued it. The block sits between the neuron accumulators and the shared activation datapath.

---
 rtl/sigmoid_sched.sv | 121 ++++++++++++
 tb/tb_sigmoid_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_sched.sv
// Round-robin issue of requester operands to one shared pipelined sigmoid unit,
// with a latency-matched tag pipeline that routes each result back to its issuer.
module sigmoid_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 17,
    parameter int LAT   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       sig_x,
    output logic               sig_valid,
    input  logic [W-1:0]       sig_y,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_data,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [W-1:0]     sig_x_q, sig_x_d;
    logic             sig_valid_q, sig_valid_d;
    logic [LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [PW-1:0]    tag_id_q [LAT];
    logic [PW-1:0]    tag_id_d [LAT];
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic             found;
    logic             transfer;
    logic [PW-1:0]    gnt_id;
    logic [W-1:0]     gnt_data;

    // Two passes: indices at or above ptr first, then the wrapped-around ones.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (req_valid[j] && !found && (j >= int'(ptr_q))) begin
                found  = 1'b1;
                gnt_id = PW'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (req_valid[j] && !found) begin
                found  = 1'b1;
                gnt_id = PW'(j);
            end
        end
    end

    assign transfer = found && enable;

    always_comb begin
        req_ready = '0;
        gnt_data  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (int'(gnt_id) == j) begin
                req_ready[j] = transfer;
                gnt_data     = req_data[j*W +: W];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        sig_x_d     = sig_x_q;
        sig_valid_d = transfer;
        if (transfer) begin
            sig_x_d = gnt_data;
            ptr_d   = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + PW'(1);
        end
    end

    // Tag stage 0 lines up with sig_valid; the tail is decoded into a register
    // so rsp_valid lands exactly LAT cycles after sig_valid, alongside sig_y.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = transfer;
        tag_id_d[0]  = gnt_id;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        rsp_valid_d = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rsp_valid_d[j] = tag_vld_q[LAT-1] && (int'(tag_id_q[LAT-1]) == j);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            sig_x_q     <= '0;
            sig_valid_q <= 1'b0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            sig_x_q     <= sig_x_d;
            sig_valid_q <= sig_valid_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign sig_x     = sig_x_q;
    assign sig_valid = sig_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = sig_y;
    assign busy      = sig_valid_q | (|tag_vld_q);

endmodule

// File: tb/tb_sigmoid_sched.sv
// Directed and random stimulus for sigmoid_sched (N_REQ=4 and N_REQ=1 instances),
// checked against a queue-based scheduler model and a 2-stage sigmoid unit model.
module tb_sigmoid_sched;

    localparam int N   = 4;
    localparam int W   = 17;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           enable;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   sig_x;
    logic           sig_valid;
    logic [W-1:0]   sig_y, y_pipe;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    logic           v1;
    logic [W-1:0]   d1;
    logic           rdy1;
    logic [W-1:0]   sx1;
    logic           sv1;
    logic [W-1:0]   sy1, y1_pipe;
    logic           rv1;
    logic [W-1:0]   rd1;
    logic           busy1;

    sigmoid_sched #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sig_x(sig_x), .sig_valid(sig_valid), .sig_y(sig_y),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    sigmoid_sched #(.N_REQ(1), .W(W), .LAT(LAT)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(v1), .req_data(d1), .req_ready(rdy1),
        .sig_x(sx1), .sig_valid(sv1), .sig_y(sy1),
        .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1)
    );

    // Stand-in for the shared sigmoid unit: any fixed function, LAT=2 stages.
    function automatic logic [W-1:0] sfun(input logic [W-1:0] x);
        return (x >> 2) + 17'h08000;
    endfunction

    always @(posedge clk) begin
        y_pipe  <= sfun(sig_x);
        sig_y   <= y_pipe;
        y1_pipe <= sfun(sx1);
        sy1     <= y1_pipe;
    end

    typedef struct {
        int           id;
        logic [W-1:0] y;
        int           due;
    } rsp_t;

    rsp_t         q[$];
    rsp_t         q1[$];
    int           m_ptr;
    int           cyc;
    logic         exp_sv, exp_sv1;
    logic [W-1:0] exp_sx, exp_sx1;
    int           glog[$];
    int           glog1[$];
    int           n_rsp1;
    int           n_chk  = 0;
    int           n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int dec(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = (r == -1) ? i : 99;
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        q1.delete();
        m_ptr   = 0;
        exp_sv  = 1'b0;
        exp_sx  = '0;
        exp_sv1 = 1'b0;
        exp_sx1 = '0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int           g, g1;
        logic [N-1:0] exp_rv;
        logic [W-1:0] exp_rd;
        logic         exp_rv1;
        logic [W-1:0] exp_rd1;
        #1;
        g  = (reset_n && enable) ? pick(req_valid, m_ptr) : -1;
        g1 = (reset_n && enable && v1) ? 0 : -1;

        exp_rv = '0;
        exp_rd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv[q[0].id] = 1'b1;
            exp_rd = q[0].y;
            void'(q.pop_front());
        end
        chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("sig_valid", sig_valid, exp_sv);
        chk("sig_x", sig_x, exp_sx);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != 0) chk("rsp_data", rsp_data, exp_rd);
        chk("busy", busy, q.size() > 0);

        exp_rv1 = 1'b0;
        exp_rd1 = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            exp_rv1 = 1'b1;
            exp_rd1 = q1[0].y;
            void'(q1.pop_front());
        end
        chk("n1_req_ready", rdy1, g1 == 0);
        chk("n1_sig_valid", sv1, exp_sv1);
        chk("n1_rsp_valid", rv1, exp_rv1);
        if (exp_rv1) chk("n1_rsp_data", rd1, exp_rd1);
        chk("n1_busy", busy1, q1.size() > 0);

        glog.push_back(dec(req_ready));
        glog1.push_back(rdy1 ? 0 : -1);
        if (rv1) n_rsp1++;

        @(posedge clk);
        cyc++;
        if (reset_n) begin
            exp_sv = (g >= 0);
            if (g >= 0) begin
                exp_sx = req_data[g*W +: W];
                q.push_back('{g, sfun(exp_sx), cyc + LAT});
                m_ptr = (g + 1) % N;
            end
            exp_sv1 = (g1 == 0);
            if (g1 == 0) begin
                exp_sx1 = d1;
                q1.push_back('{0, sfun(d1), cyc + LAT});
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        d1 = W'($urandom);
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        v1 = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int exp_order[8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        cyc = 0;
        n_rsp1 = 0;
        reset_n = 1'b0;
        enable = 1'b1;
        req_valid = '0;
        req_data = '0;
        v1 = 1'b0;
        d1 = '0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        reset_n = 1'b1;

        // Single request on requester 2 with a zero operand.
        rand_data();
        req_data[2*W +: W] = '0;
        req_valid = 4'b0100;
        glog.delete();
        cycle();
        chk("single_grant", glog[0], 2);
        idle(4);
        chk("single_busy_after", busy, 0);

        // Move the pointer back to 0, then all four requesters for 8 cycles.
        req_valid = 4'b1000;
        cycle();
        glog.delete();
        for (int i = 0; i < 8; i++) begin
            rand_data();
            req_valid = 4'hF;
            cycle();
        end
        for (int i = 0; i < 8; i++) chk("rr_order", glog[i], exp_order[i]);
        idle(3);

        // Requesters 1 and 3 competing with the pointer at 2.
        req_valid = 4'b0010;
        cycle();
        glog.delete();
        for (int i = 0; i < 3; i++) begin
            rand_data();
            req_valid = 4'b1010;
            cycle();
        end
        chk("p2_grant0", glog[0], 3);
        chk("p2_grant1", glog[1], 1);
        chk("p2_grant2", glog[2], 3);

        // Two in flight, then enable drops while requester 0 waits.
        rand_data();
        req_valid = 4'b0110;
        cycle();
        req_valid = 4'b0100;
        cycle();
        enable = 1'b0;
        req_valid = 4'b0001;
        glog.delete();
        for (int i = 0; i < 4; i++) cycle();
        enable = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) chk("disabled_no_grant", glog[i], -1);
        chk("reenable_grant0", glog[4], 0);
        idle(3);

        // Reset right after three back-to-back accepts.
        for (int i = 0; i < 3; i++) begin
            rand_data();
            req_valid = 4'hF;
            cycle();
        end
        req_valid = '0;
        reset_n = 1'b0;
        model_reset();
        cycle();
        reset_n = 1'b1;
        idle(4);
        chk("post_reset_busy", busy, 0);
        rand_data();
        req_valid = 4'hF;
        glog.delete();
        cycle();
        chk("post_reset_ptr0", glog[0], 0);
        idle(3);

        // Single-requester instance, continuous valid for 5 cycles.
        glog1.delete();
        n_rsp1 = 0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            v1 = 1'b1;
            cycle();
        end
        idle(4);
        for (int i = 0; i < 5; i++) chk("n1_ready_high", glog1[i], 0);
        chk("n1_rsp_count", n_rsp1, 5);

        // Random traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            rand_data();
            req_valid = N'($urandom_range(0, 15));
            v1 = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            cycle();
        end
        enable = 1'b1;
        idle(4);
        chk("final_busy", busy, 0);
        chk("final_busy_n1", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
